// File: rtl/axi_arb_pkg.sv
// Shared types and AXI constants for the write arbiter.
package axi_arb_pkg;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_RESP = 2'd3
  } arb_state_e;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after i_ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_CH = 5,
  parameter int PW     = 3
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [PW-1:0]     i_ptr,
  output logic [NUM_CH-1:0] o_gnt,
  output logic [PW-1:0]     o_idx,
  output logic              o_any
);
  always_comb begin
    int c;
    c     = 0;
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int off = 0; off < NUM_CH; off++) begin
      c = int'(i_ptr) + off;
      if (c >= NUM_CH) c = c - NUM_CH;
      if (!o_any && i_req[c]) begin
        o_any    = 1'b1;
        o_gnt[c] = 1'b1;
        o_idx    = PW'(c);
      end
    end
  end
endmodule

// File: rtl/axi_wr_arbiter.sv
// Round-robin AXI4 write master: one full burst outstanding, camera FIFOs as sources.
module axi_wr_arbiter
  import axi_arb_pkg::*;
#(
  parameter int NUM_CH    = 5,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 128,
  parameter int BURST_LEN = 32
) (
  input  logic                     M_AXI_ACLK,
  input  logic                     M_AXI_ARESETN,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic [NUM_CH-1:0]        ch_grant,
  output logic [NUM_CH-1:0]        ch_rd_en,
  output logic [NUM_CH-1:0]        ch_done,
  output logic [ADDR_W-1:0]        M_AXI_AWADDR,
  output logic [7:0]               M_AXI_AWLEN,
  output logic [2:0]               M_AXI_AWSIZE,
  output logic [1:0]               M_AXI_AWBURST,
  output logic                     M_AXI_AWVALID,
  input  logic                     M_AXI_AWREADY,
  output logic [DATA_W-1:0]        M_AXI_WDATA,
  output logic [DATA_W/8-1:0]      M_AXI_WSTRB,
  output logic                     M_AXI_WLAST,
  output logic                     M_AXI_WVALID,
  input  logic                     M_AXI_WREADY,
  input  logic [1:0]               M_AXI_BRESP,
  input  logic                     M_AXI_BVALID,
  output logic                     M_AXI_BREADY,
  output logic                     resp_err
);
  localparam int PW = idx_w(NUM_CH);
  localparam int BW = $clog2(BURST_LEN + 1);

  arb_state_e r_state, w_nxt;

  logic [NUM_CH-1:0]             r_grant;
  logic [PW-1:0]                 r_gidx, r_rr_ptr;
  logic [ADDR_W-1:0]             r_addr;
  logic [BW-1:0]                 r_beat;
  logic                          r_resp_err;

  logic [NUM_CH-1:0][ADDR_W-1:0] w_addr;
  logic [NUM_CH-1:0][DATA_W-1:0] w_data;
  logic [NUM_CH-1:0]             w_gnt;
  logic [PW-1:0]                 w_gidx;
  logic                          w_any, w_last, w_whs, w_bhs;

  assign w_addr = ch_addr;
  assign w_data = ch_data;

  rr_arbiter #(.NUM_CH(NUM_CH), .PW(PW)) u_rr (
    .i_req (ch_req),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_gidx),
    .o_any (w_any)
  );

  assign w_last = (r_beat == BW'(BURST_LEN - 1));
  assign w_whs  = (r_state == S_DATA) && M_AXI_WREADY;
  assign w_bhs  = (r_state == S_RESP) && M_AXI_BVALID;

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) r_state <= S_IDLE;
    else                r_state <= w_nxt;
  end

  always_comb begin
    w_nxt         = r_state;
    M_AXI_AWVALID = 1'b0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_WLAST   = 1'b0;
    M_AXI_BREADY  = 1'b0;
    unique case (r_state)
      S_IDLE: if (w_any) w_nxt = S_ADDR;
      S_ADDR: begin
        M_AXI_AWVALID = 1'b1;
        if (M_AXI_AWREADY) w_nxt = S_DATA;
      end
      S_DATA: begin
        M_AXI_WVALID = 1'b1;
        M_AXI_WLAST  = w_last;
        if (w_whs && w_last) w_nxt = S_RESP;
      end
      S_RESP: begin
        M_AXI_BREADY = 1'b1;
        if (M_AXI_BVALID) w_nxt = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  // Grant, address and index are captured once in IDLE, so later ch_req changes cannot disturb the burst.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      r_grant    <= '0;
      r_gidx     <= '0;
      r_rr_ptr   <= '0;
      r_addr     <= '0;
      r_beat     <= '0;
      r_resp_err <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_any) begin
        r_grant <= w_gnt;
        r_gidx  <= w_gidx;
        r_addr  <= w_addr[w_gidx];
      end
      if (w_whs) r_beat <= w_last ? '0 : r_beat + 1'b1;
      if (w_bhs) begin
        r_grant  <= '0;
        r_rr_ptr <= (r_gidx == PW'(NUM_CH - 1)) ? '0 : r_gidx + 1'b1;
        if (M_AXI_BRESP != RESP_OKAY) r_resp_err <= 1'b1;
      end
    end
  end

  assign ch_grant      = r_grant;
  assign ch_rd_en      = r_grant & {NUM_CH{w_whs}};
  assign ch_done       = r_grant & {NUM_CH{w_bhs}};
  assign resp_err      = r_resp_err;
  assign M_AXI_AWADDR  = r_addr;
  assign M_AXI_AWLEN   = 8'(BURST_LEN - 1);
  assign M_AXI_AWSIZE  = 3'($clog2(DATA_W / 8));
  assign M_AXI_AWBURST = BURST_INCR;
  assign M_AXI_WDATA   = M_AXI_WVALID ? w_data[r_gidx] : '0;
  assign M_AXI_WSTRB   = '1;
endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed bench for axi_wr_arbiter: single burst, round-robin, stalls, error response, mid-burst reset.
module tb_axi_wr_arbiter;
  localparam int NCH = 5;
  localparam int AW  = 32;
  localparam int DW  = 128;
  localparam int BL  = 32;

  logic              clk, rst_n;
  logic [NCH-1:0]    ch_req;
  logic [NCH*AW-1:0] ch_addr;
  logic [NCH*DW-1:0] ch_data;
  logic [NCH-1:0]    ch_grant, ch_rd_en, ch_done;
  logic [AW-1:0]     awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst, bresp;
  logic              awvalid, awready, wlast, wvalid, wready, bvalid, bready, resp_err;
  logic [DW-1:0]     wdata;
  logic [DW/8-1:0]   wstrb;

  axi_wr_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL)) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
    .ch_req(ch_req), .ch_addr(ch_addr), .ch_data(ch_data),
    .ch_grant(ch_grant), .ch_rd_en(ch_rd_en), .ch_done(ch_done),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize), .M_AXI_AWBURST(awburst),
    .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast),
    .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .resp_err(resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0, aw_cnt = 0, done_total = 0, burst_hs = 0, total_hs = 0;
  int stab_err = 0, data_err = 0, pop_err = 0, wlast_err = 0, beats_err = 0, onehot_err = 0;
  int min_gap = 1000, max_gap = 0, done_cyc = 0;
  bit has_done = 0, aw_stall = 0, w_stall = 0, prev_awv = 0, rnd = 0, err_on = 0;
  int pops [NCH];
  int unsigned fifo [NCH];
  int unsigned exp_ptr [NCH];
  logic [NCH-1:0] pop_pend = '0;
  int gq[$], dq[$];
  logic [AW-1:0] last_addr, st_addr;
  logic [7:0]    last_len;
  logic [2:0]    last_size;
  logic [1:0]    last_burst;
  logic [DW-1:0] st_data;

  function automatic logic [DW-1:0] mkdata(input int ch, input int unsigned p);
    return {64'd0, 32'(ch), 32'(p)};
  endfunction

  function automatic int oh2i(input logic [NCH-1:0] v);
    for (int i = 0; i < NCH; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    aw_cnt = 0; done_total = 0; total_hs = 0; has_done = 0;
    stab_err = 0; data_err = 0; pop_err = 0; wlast_err = 0; beats_err = 0; onehot_err = 0;
    min_gap = 1000; max_gap = 0;
    gq.delete(); dq.delete();
    for (int i = 0; i < NCH; i++) pops[i] = 0;
  endtask

  task automatic wait_aw(input int n, input string tag);
    int k = 0;
    while (aw_cnt < n && k < 5000) begin @(negedge clk); #1; k++; end
    chk({tag, "_aw_timeout"}, 128'(aw_cnt >= n), 128'd1);
  endtask

  task automatic wait_done(input int n, input string tag);
    int k = 0;
    while (done_total < n && k < 5000) begin @(negedge clk); #1; k++; end
    chk({tag, "_done_timeout"}, 128'(done_total >= n), 128'd1);
  endtask

  task automatic wait_hs(input int n, input string tag);
    int k = 0;
    while (burst_hs < n && k < 5000) begin @(negedge clk); #1; k++; end
    chk({tag, "_hs_timeout"}, 128'(burst_hs >= n), 128'd1);
  endtask

  task automatic reset_pulse();
    @(negedge clk); #1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Requester FIFO models and slave ready/response driving, updated just after each rising edge.
  initial begin
    for (int i = 0; i < NCH; i++) begin
      fifo[i] = 0; exp_ptr[i] = 0;
      ch_data[i*DW +: DW] = mkdata(i, 0);
      ch_addr[i*AW +: AW] = 32'h0E00_0000 + 32'(i) * 32'h0100_0000;
    end
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < NCH; i++) begin
        if (pop_pend[i]) fifo[i]++;
        ch_data[i*DW +: DW] = mkdata(i, fifo[i]);
      end
      pop_pend = '0;
      awready = rnd ? ($urandom_range(0, 2) == 0) : 1'b1;
      wready  = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      bresp   = (err_on && done_total == 1) ? 2'b10 : 2'b00;
    end
  end

  // Protocol monitor, sampled mid-cycle.
  initial forever begin
    logic [NCH-1:0] exp_rd;
    int g;
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      burst_hs = 0; aw_stall = 0; w_stall = 0; has_done = 0; prev_awv = 0; pop_pend = '0;
    end else begin
      if (awvalid) begin
        if (aw_stall && (awaddr !== st_addr || awlen !== last_len || awsize !== last_size || awburst !== last_burst))
          stab_err++;
        if (!$onehot(ch_grant)) onehot_err++;
        if (!prev_awv && has_done) begin
          if (cyc - done_cyc < min_gap) min_gap = cyc - done_cyc;
          if (cyc - done_cyc > max_gap) max_gap = cyc - done_cyc;
        end
        last_len = awlen; last_size = awsize; last_burst = awburst;
        if (awready) begin
          aw_cnt++; last_addr = awaddr; gq.push_back(oh2i(ch_grant)); aw_stall = 0;
        end else begin
          aw_stall = 1; st_addr = awaddr;
        end
      end
      prev_awv = awvalid;
      exp_rd = '0;
      if (wvalid) begin
        if (w_stall && wdata !== st_data) stab_err++;
        if (wready) begin
          g = oh2i(ch_grant);
          exp_rd = ch_grant;
          if (g < 0) data_err++;
          else begin
            if (wdata !== mkdata(g, exp_ptr[g])) data_err++;
            exp_ptr[g]++;
          end
          if (wlast !== (burst_hs == BL - 1)) wlast_err++;
          burst_hs++; total_hs++; w_stall = 0;
        end else begin
          w_stall = 1; st_data = wdata;
        end
      end
      if (ch_rd_en !== exp_rd) pop_err++;
      pop_pend = ch_rd_en;
      for (int i = 0; i < NCH; i++) pops[i] += int'(ch_rd_en[i]);
      if (|ch_done) begin
        done_total++; dq.push_back(oh2i(ch_done));
        if (ch_done !== ch_grant) onehot_err++;
        if (burst_hs != BL) beats_err++;
        burst_hs = 0; has_done = 1; done_cyc = cyc;
      end
    end
  end

  initial begin
    rst_n = 1'b0; ch_req = '0;
    repeat (2) @(negedge clk); #1;
    chk("rst_awvalid", 128'(awvalid), 128'd0);
    chk("rst_wvalid",  128'(wvalid),  128'd0);
    chk("rst_bready",  128'(bready),  128'd0);
    chk("rst_grant",   128'(ch_grant), 128'd0);
    chk("rst_rd_en",   128'(ch_rd_en), 128'd0);
    chk("rst_done",    128'(ch_done),  128'd0);
    chk("rst_resp_err",128'(resp_err), 128'd0);
    chk("rst_awaddr",  128'(awaddr),   128'd0);
    @(negedge clk); #1 rst_n = 1'b1;

    // Single channel burst; request dropped once the address is out.
    clr();
    ch_req = 5'b00100;
    wait_aw(1, "t1");
    ch_req = '0;
    wait_done(1, "t1");
    repeat (4) @(negedge clk); #1;
    chk("t1_awaddr", 128'(last_addr), 128'h1000_0000);
    chk("t1_awlen",  128'(last_len),  128'd31);
    chk("t1_awsize", 128'(last_size), 128'd4);
    chk("t1_awburst",128'(last_burst),128'd1);
    chk("t1_wstrb",  128'(wstrb),     {112'd0, 16'hFFFF});
    chk("t1_beats",  128'(total_hs),  128'd32);
    chk("t1_pops2",  128'(pops[2]),   128'd32);
    chk("t1_pops0",  128'(pops[0] + pops[1] + pops[3] + pops[4]), 128'd0);
    chk("t1_done_n", 128'(dq.size()), 128'd1);
    chk("t1_done_ch",128'(dq[0]),     128'd2);
    chk("t1_aw_n",   128'(aw_cnt),    128'd1);
    chk("t1_grant_after", 128'(ch_grant), 128'd0);
    chk("t1_wlast",  128'(wlast_err), 128'd0);
    chk("t1_data",   128'(data_err),  128'd0);
    chk("t1_pop",    128'(pop_err),   128'd0);

    // All channels requesting: full rotation then wrap to channel 0.
    reset_pulse();
    clr();
    ch_req = 5'b11111;
    wait_aw(6, "t2");
    ch_req = '0;
    wait_done(6, "t2");
    chk("t2_aw_n", 128'(gq.size()), 128'd6);
    for (int i = 0; i < 6; i++) chk($sformatf("t2_grant%0d", i), 128'(gq[i]), 128'(i % 5));
    chk("t2_min_gap", 128'(min_gap), 128'd2);
    chk("t2_max_gap", 128'(max_gap), 128'd2);
    chk("t2_onehot",  128'(onehot_err), 128'd0);
    chk("t2_beats",   128'(beats_err),  128'd0);

    // Random AW/W stalls.
    reset_pulse();
    clr();
    rnd = 1;
    ch_req = 5'b01011;
    wait_aw(3, "t3");
    ch_req = '0;
    wait_done(3, "t3");
    rnd = 0;
    chk("t3_order0", 128'(gq[0]), 128'd0);
    chk("t3_order1", 128'(gq[1]), 128'd1);
    chk("t3_order2", 128'(gq[2]), 128'd3);
    chk("t3_stable", 128'(stab_err),  128'd0);
    chk("t3_data",   128'(data_err),  128'd0);
    chk("t3_pop",    128'(pop_err),   128'd0);
    chk("t3_wlast",  128'(wlast_err), 128'd0);
    chk("t3_beats",  128'(beats_err), 128'd0);
    chk("t3_pops0",  128'(pops[0]),   128'd32);
    chk("t3_pops1",  128'(pops[1]),   128'd32);
    chk("t3_pops3",  128'(pops[3]),   128'd32);

    // SLVERR on the second burst: sticky until reset.
    reset_pulse();
    clr();
    err_on = 1;
    ch_req = 5'b00011;
    wait_done(1, "t4");
    @(negedge clk); #1;
    chk("t4_err_after1", 128'(resp_err), 128'd0);
    wait_done(2, "t4");
    @(negedge clk); #1;
    chk("t4_err_after2", 128'(resp_err), 128'd1);
    wait_aw(4, "t4");
    ch_req = '0;
    wait_done(4, "t4");
    @(negedge clk); #1;
    chk("t4_err_after4", 128'(resp_err), 128'd1);
    err_on = 0;
    rst_n = 1'b0; #1;
    chk("t4_err_reset", 128'(resp_err), 128'd0);
    repeat (2) @(negedge clk); #1 rst_n = 1'b1;

    // Reset mid-burst on channel 3.
    clr();
    ch_req = 5'b01000;
    wait_aw(1, "t5");
    wait_hs(10, "t5");
    rst_n = 1'b0; #1;
    chk("t5_awvalid", 128'(awvalid),  128'd0);
    chk("t5_wvalid",  128'(wvalid),   128'd0);
    chk("t5_bready",  128'(bready),   128'd0);
    chk("t5_grant",   128'(ch_grant), 128'd0);
    chk("t5_rd_en",   128'(ch_rd_en), 128'd0);
    ch_req = 5'b11010;
    repeat (2) @(negedge clk); #1;
    chk("t5_no_done", 128'(done_total), 128'd0);
    clr();
    rst_n = 1'b1;
    wait_aw(1, "t5b");
    ch_req = '0;
    chk("t5_first_grant", 128'(gq[0]), 128'd1);
    wait_done(1, "t5b");
    chk("t5_done_ch", 128'(dq[0]),    128'd1);
    chk("t5_data",    128'(data_err), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
